// File: rtl/alu_result_fifo.sv
// Show-ahead FIFO buffering ALU results {sel, ret} for a valid/ready consumer.
// Tracks occupancy, a sticky overflow flag and a wrapping accepted-push counter.
module alu_result_fifo #(
  parameter int DATA_W = 5,
  parameter int TAG_W  = 3,
  parameter int DEPTH  = 4,
  parameter int ACC_W  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_sel,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_sel,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [ACC_W-1:0]  accepted
);

  localparam int ENTRY_W = TAG_W + DATA_W;

  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;
  logic [ACC_W-1:0] accepted_reg;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;
  logic [ENTRY_W-1:0] head;

  // Flags come only from the registered count, so out_ready never reaches in_ready.
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign push  = in_valid & ~full;
  assign pop   = out_ready & ~empty;
  assign drop  = in_valid & full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {in_sel, in_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      accepted_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
        accepted_reg <= accepted_reg + ACC_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
      // A dropped write in the same cycle as a clear leaves the flag set.
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clr_ovf) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign head      = mem[rd_ptr_reg];
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : head[DATA_W-1:0];
  assign out_sel   = empty ? '0 : head[ENTRY_W-1:DATA_W];
  assign count     = count_reg;
  assign overflow  = overflow_reg;
  assign accepted  = accepted_reg;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: vector table plus hand-written reset and counter-wrap sequences.
module tb_alu_result_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [4:0] in_data;
  logic [2:0] in_sel;
  logic       in_ready;
  logic       out_valid;
  logic [4:0] out_data;
  logic [2:0] out_sel;
  logic       out_ready;
  logic [2:0] count;
  logic       overflow;
  logic       clr_ovf;
  logic [7:0] accepted;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_result_fifo #(.DATA_W(5), .TAG_W(3), .DEPTH(4), .ACC_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready),
    .count(count), .overflow(overflow), .clr_ovf(clr_ovf), .accepted(accepted)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic [4:0] id;
    logic [2:0] is;
    logic       ordy;
    logic       clr;
    logic [2:0] e_cnt;
    logic       e_ov;
    logic [4:0] e_od;
    logic [2:0] e_os;
    logic       e_ir;
    logic       e_ovf;
    logic [7:0] e_acc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic iv, logic [4:0] id, logic [2:0] is,
                              logic ordy, logic clr, logic [2:0] c, logic ov,
                              logic [4:0] od, logic [2:0] os, logic ir, logic ovf,
                              logic [7:0] acc);
    vec_t v;
    v.rst = r; v.iv = iv; v.id = id; v.is = is; v.ordy = ordy; v.clr = clr;
    v.e_cnt = c; v.e_ov = ov; v.e_od = od; v.e_os = os; v.e_ir = ir;
    v.e_ovf = ovf; v.e_acc = acc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".count"},     32'(count),     32'(v.e_cnt));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v.e_ov));
    check({tag, ".out_data"},  32'(out_data),  32'(v.e_od));
    check({tag, ".out_sel"},   32'(out_sel),   32'(v.e_os));
    check({tag, ".in_ready"},  32'(in_ready),  32'(v.e_ir));
    check({tag, ".overflow"},  32'(overflow),  32'(v.e_ovf));
    check({tag, ".accepted"},  32'(accepted),  32'(v.e_acc));
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = 1'b0; clr_ovf = 1'b0;
  endtask

  // Async reset pulse placed mid-cycle, checked before any clock edge.
  task automatic pulse_reset(input string tag);
    vec_t z;
    z = mk(1, 0, 0, 0, 0, 0, 3'd0, 0, 5'd0, 3'd0, 1, 0, 8'd0);
    @(negedge clk);
    idle_inputs();
    #1 rst = 1'b1;
    #1 check_all(tag, z);
    rst = 1'b0;
  endtask

  initial begin
    vec_t v;
    vec_t rv;
    rst = 1'b1;
    idle_inputs();
    rv = mk(1, 0, 0, 0, 0, 0, 3'd0, 0, 5'd0, 3'd0, 1, 0, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_all("reset", rv);

    // Reset mid-stream with three entries queued and overflow already set.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 5'(i + 3); in_sel = 3'(i);
    end
    @(negedge clk);
    idle_inputs();
    check("pre_rst.count", 32'(count), 32'd4);
    check("pre_rst.overflow", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("pre_rst.count3", 32'(count), 32'd3);
    pulse_reset("midrst");
    $display("txn midstream_reset: count=%0d out_valid=%0b accepted=%0d", count, out_valid, accepted);

    // Single pass, then no fall-through on a push into an empty FIFO with out_ready high.
    vecs.push_back(mk(0, 1, 5'b01100, 3'b000, 0, 0, 3'd1, 1, 5'b01100, 3'b000, 1, 0, 8'd1));
    vecs.push_back(mk(0, 0, 5'b00000, 3'b000, 1, 0, 3'd0, 0, 5'b00000, 3'b000, 1, 0, 8'd1));
    vecs.push_back(mk(0, 1, 5'b00111, 3'b011, 1, 0, 3'd1, 1, 5'b00111, 3'b011, 1, 0, 8'd2));
    vecs.push_back(mk(0, 0, 5'b00000, 3'b000, 1, 0, 3'd0, 0, 5'b00000, 3'b000, 1, 0, 8'd2));
    vecs.push_back(mk(1, 0, 5'b00000, 3'b000, 0, 0, 3'd0, 0, 5'b00000, 3'b000, 1, 0, 8'd0));
    // Fill to four, overflow with and without a same-cycle pop, clear, drain in order.
    vecs.push_back(mk(0, 1, 5'b01100, 3'b000, 0, 0, 3'd1, 1, 5'b01100, 3'b000, 1, 0, 8'd1));
    vecs.push_back(mk(0, 1, 5'b00100, 3'b111, 0, 0, 3'd2, 1, 5'b01100, 3'b000, 1, 0, 8'd2));
    vecs.push_back(mk(0, 1, 5'b00101, 3'b100, 0, 0, 3'd3, 1, 5'b01100, 3'b000, 1, 0, 8'd3));
    vecs.push_back(mk(0, 1, 5'b00010, 3'b101, 0, 0, 3'd4, 1, 5'b01100, 3'b000, 0, 0, 8'd4));
    vecs.push_back(mk(0, 1, 5'b11111, 3'b111, 0, 1, 3'd4, 1, 5'b01100, 3'b000, 0, 1, 8'd4));
    vecs.push_back(mk(0, 1, 5'b11111, 3'b111, 1, 0, 3'd3, 1, 5'b00100, 3'b111, 1, 1, 8'd4));
    vecs.push_back(mk(0, 0, 5'b00000, 3'b000, 0, 1, 3'd3, 1, 5'b00100, 3'b111, 1, 0, 8'd4));
    vecs.push_back(mk(0, 0, 5'b00000, 3'b000, 1, 0, 3'd2, 1, 5'b00101, 3'b100, 1, 0, 8'd4));
    vecs.push_back(mk(0, 0, 5'b00000, 3'b000, 1, 0, 3'd1, 1, 5'b00010, 3'b101, 1, 0, 8'd4));
    vecs.push_back(mk(0, 0, 5'b00000, 3'b000, 1, 0, 3'd0, 0, 5'b00000, 3'b000, 1, 0, 8'd4));
    vecs.push_back(mk(0, 0, 5'b00000, 3'b000, 1, 0, 3'd0, 0, 5'b00000, 3'b000, 1, 0, 8'd4));
    vecs.push_back(mk(1, 0, 5'b00000, 3'b000, 0, 0, 3'd0, 0, 5'b00000, 3'b000, 1, 0, 8'd0));
    // Two queued, then six simultaneous push+pop edges: pointers wrap twice.
    vecs.push_back(mk(0, 1, 5'b00001, 3'b001, 0, 0, 3'd2 - 3'd1, 1, 5'b00001, 3'b001, 1, 0, 8'd1));
    vecs.push_back(mk(0, 1, 5'b00010, 3'b010, 0, 0, 3'd2, 1, 5'b00001, 3'b001, 1, 0, 8'd2));
    vecs.push_back(mk(0, 1, 5'b00011, 3'b011, 1, 0, 3'd2, 1, 5'b00010, 3'b010, 1, 0, 8'd3));
    vecs.push_back(mk(0, 1, 5'b00100, 3'b100, 1, 0, 3'd2, 1, 5'b00011, 3'b011, 1, 0, 8'd4));
    vecs.push_back(mk(0, 1, 5'b00101, 3'b101, 1, 0, 3'd2, 1, 5'b00100, 3'b100, 1, 0, 8'd5));
    vecs.push_back(mk(0, 1, 5'b00110, 3'b110, 1, 0, 3'd2, 1, 5'b00101, 3'b101, 1, 0, 8'd6));
    vecs.push_back(mk(0, 1, 5'b00111, 3'b111, 1, 0, 3'd2, 1, 5'b00110, 3'b110, 1, 0, 8'd7));
    vecs.push_back(mk(0, 1, 5'b01000, 3'b000, 1, 0, 3'd2, 1, 5'b00111, 3'b111, 1, 0, 8'd8));
    vecs.push_back(mk(0, 0, 5'b00000, 3'b000, 1, 0, 3'd1, 1, 5'b01000, 3'b000, 1, 0, 8'd8));
    vecs.push_back(mk(0, 0, 5'b00000, 3'b000, 1, 0, 3'd0, 0, 5'b00000, 3'b000, 1, 0, 8'd8));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst) begin
        pulse_reset($sformatf("v%0d", i));
      end else begin
        @(negedge clk);
        in_valid = v.iv; in_data = v.id; in_sel = v.is;
        out_ready = v.ordy; clr_ovf = v.clr;
        @(posedge clk);
        #1 check_all($sformatf("v%0d", i), v);
      end
      $display("txn v%0d: rst=%0b iv=%0b d=%b s=%b ordy=%0b clr=%0b -> cnt=%0d ov=%0b od=%b os=%b ir=%0b ovf=%0b acc=%0d",
               i, v.rst, v.iv, v.id, v.is, v.ordy, v.clr,
               count, out_valid, out_data, out_sel, in_ready, overflow, accepted);
    end

    // 256 pushes with continuous draining: accepted wraps back to zero.
    pulse_reset("wrap_rst");
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 5'(i); in_sel = 3'(i); out_ready = 1'b1; clr_ovf = 1'b0;
      @(posedge clk);
      #1;
      if (i == 254) check("wrap.acc255", 32'(accepted), 32'd255);
    end
    check("wrap.accepted", 32'(accepted), 32'd0);
    check("wrap.overflow", 32'(overflow), 32'd0);
    check("wrap.count",    32'(count),    32'd1);
    check("wrap.out_data", 32'(out_data), 32'd31);
    check("wrap.out_sel",  32'(out_sel),  32'd7);
    $display("txn wrap256: accepted=%0d overflow=%0b count=%0d", accepted, overflow, count);

    @(negedge clk);
    idle_inputs();
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("final.count", 32'(count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
